// File: rtl/dmem_ctlr_pkg.sv
// Shared types for the data-memory controller: RV32 access sizes, controller
// states and the byte-enable helper used by both the store path and the top level.
package dmem_pkg;

    typedef enum logic [1:0] {
        SZ_BYTE    = 2'b00,
        SZ_HALF    = 2'b01,
        SZ_WORD    = 2'b10,
        SZ_ILLEGAL = 2'b11
    } size_e;

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_RUN   = 1'b1
    } state_e;

    // Byte enables for an access of the given size starting at byte lane `lane`.
    // Misaligned halves still produce a pattern; the caller suppresses erroneous writes.
    function automatic logic [3:0] byte_en(input size_e size, input logic [1:0] lane);
        logic [3:0] be;
        case (size)
            SZ_BYTE: be = 4'b0001 << lane;
            SZ_HALF: be = 4'b0011 << lane;
            SZ_WORD: be = 4'b1111;
            default: be = 4'b0000;
        endcase
        return be;
    endfunction

endpackage

// File: rtl/dmem_ctlr_lane_fmt.sv
// Combinational lane formatting: replicates store data across byte lanes with
// matching enables, and extracts/extends load data from the addressed lane.
module dmem_lane_fmt
    import dmem_pkg::*;
(
    input  size_e       size,
    input  logic [1:0]  lane,
    input  logic        load_unsigned,
    input  logic [31:0] wdata,
    input  logic [31:0] rword,
    output logic [31:0] wdata_lanes,
    output logic [3:0]  be,
    output logic [31:0] rdata
);

    logic [7:0]  rbyte;
    logic [15:0] rhalf;

    // NOTE: every output of this block gets a value before the case so no path leaves it unassigned (no latch).
    always_comb begin
        be          = byte_en(size, lane);
        rbyte       = rword[{lane, 3'b000} +: 8];
        rhalf       = lane[1] ? rword[31:16] : rword[15:0];
        wdata_lanes = wdata;
        rdata       = rword;
        case (size)
            SZ_BYTE: begin
                // Replicating lets the byte enables alone pick the destination lane.
                wdata_lanes = {4{wdata[7:0]}};
                rdata       = {{24{~load_unsigned & rbyte[7]}}, rbyte};
            end
            SZ_HALF: begin
                wdata_lanes = {2{wdata[15:0]}};
                rdata       = {{16{~load_unsigned & rhalf[15]}}, rhalf};
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/dmem_ctlr.sv
// Data-memory controller: word-organised RAM with byte/half/word access, a
// post-reset zeroing sweep, access checking and a single-entry response buffer.
module dmem_ctlr
    import dmem_pkg::*;
#(
    parameter int unsigned DEPTH     = 128,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
);

    localparam int unsigned IDX_W = $clog2(DEPTH);

    logic [31:0]      mem [DEPTH];
    state_e           state;
    logic [IDX_W-1:0] clr_cnt;

    size_e            size;
    logic [31:0]      offset;
    logic [IDX_W-1:0] word_idx;
    logic [1:0]       lane;
    logic             misaligned;
    logic             out_of_range;
    logic             acc_err;
    logic             accept;
    logic [31:0]      rword;
    logic [31:0]      wdata_lanes;
    logic [31:0]      load_data;
    logic [3:0]       be;

    assign size     = size_e'(req_size);
    assign offset   = req_addr - BASE_ADDR;
    assign word_idx = offset[IDX_W+1:2];
    assign lane     = offset[1:0];

    // Unsigned offset: addresses below BASE_ADDR wrap to huge values and fail here too.
    assign out_of_range = (offset >> (IDX_W + 2)) != 32'd0;

    always_comb begin
        case (size)
            SZ_BYTE: misaligned = 1'b0;
            SZ_HALF: misaligned = lane[0];
            SZ_WORD: misaligned = lane != 2'b00;
            default: misaligned = 1'b1;
        endcase
    end

    assign acc_err   = misaligned | out_of_range;
    assign req_ready = (state == ST_RUN) && (!rsp_valid || rsp_ready);
    assign accept    = req_valid && req_ready;
    assign rword     = mem[word_idx];

    dmem_lane_fmt u_lane_fmt (
        .size          (size),
        .lane          (lane),
        .load_unsigned (req_unsigned),
        .wdata         (req_wdata),
        .rword         (rword),
        .wdata_lanes   (wdata_lanes),
        .be            (be),
        .rdata         (load_data)
    );

    // NOTE: the array has no reset branch; the CLEAR sweep zeroes it one word per cycle instead.
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (state == ST_CLEAR) begin
                mem[clr_cnt] <= '0;
            end else if (accept && req_we && !acc_err) begin
                for (int i = 0; i < 4; i++) begin
                    if (be[i]) begin
                        mem[word_idx][8*i +: 8] <= wdata_lanes[8*i +: 8];
                    end
                end
            end
        end
    end

    // NOTE: all registered state uses <= so every read in this block sees pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_CLEAR;
            clr_cnt   <= '0;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
        end else begin
            case (state)
                ST_CLEAR: begin
                    clr_cnt <= clr_cnt + IDX_W'(1);
                    if (clr_cnt == IDX_W'(DEPTH - 1)) begin
                        state <= ST_RUN;
                    end
                end
                ST_RUN:  ;
                default: state <= ST_CLEAR;
            endcase

            // A new accept may coincide with the hand-off of the previous response.
            if (accept) begin
                rsp_valid <= 1'b1;
                rsp_err   <= acc_err;
                rsp_rdata <= (req_we || acc_err) ? 32'd0 : load_data;
            end else if (rsp_ready) begin
                rsp_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_dmem_ctlr.sv
// Scoreboard bench for dmem_ctlr: expected responses are queued at request
// acceptance and compared in order as the DUT hands responses off.
module tb_dmem_ctlr;

    localparam int unsigned DEPTH = 16;
    localparam logic [31:0] BASE  = 32'h0000_1000;
    localparam logic [1:0]  SZB   = 2'b00;
    localparam logic [1:0]  SZH   = 2'b01;
    localparam logic [1:0]  SZW   = 2'b10;
    localparam logic [1:0]  SZX   = 2'b11;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [31:0] req_addr;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_err;

    dmem_ctlr #(.DEPTH(DEPTH), .BASE_ADDR(BASE)) dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_we       (req_we),
        .req_addr     (req_addr),
        .req_size     (req_size),
        .req_unsigned (req_unsigned),
        .req_wdata    (req_wdata),
        .rsp_valid    (rsp_valid),
        .rsp_ready    (rsp_ready),
        .rsp_rdata    (rsp_rdata),
        .rsp_err      (rsp_err)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] rdata;
        logic        err;
    } rsp_t;

    rsp_t exp_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   n_rsp = 0;

    // Inputs change only at posedge+1, so the negedge sees the values the next edge will use.
    always @(negedge clk) begin : monitor
        rsp_t want;
        if (!rst && rsp_valid && rsp_ready) begin
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_bad++;
                $display("FAIL rsp_unexpected[%0d]: got rdata=%h err=%b, want no response", n_rsp, rsp_rdata, rsp_err);
            end else begin
                want = exp_q.pop_front();
                if ({rsp_rdata, rsp_err} !== want) begin
                    n_bad++;
                    $display("FAIL rsp[%0d]: got rdata=%h err=%b, want rdata=%h err=%b",
                             n_rsp, rsp_rdata, rsp_err, want.rdata, want.err);
                end
            end
            n_rsp++;
        end
    end

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, want finish before 2000000");
        $fatal(1, "watchdog expired");
    end

    // Presents one request until accepted; called and returning at posedge+1.
    task automatic send(input logic we, input logic [31:0] addr, input logic [1:0] size,
                        input logic uns, input logic [31:0] wdata, input logic [31:0] exp_rdata,
                        input logic exp_err, input bit expect_rsp, output time t_acc);
        int waited = 0;
        t_acc        = 0;
        req_valid    = 1'b1;
        req_we       = we;
        req_addr     = addr;
        req_size     = size;
        req_unsigned = uns;
        req_wdata    = wdata;
        while (1) begin
            @(negedge clk);
            if (req_ready === 1'b1) begin
                t_acc = $time;
                if (expect_rsp) exp_q.push_back({exp_rdata, exp_err});
                @(posedge clk); #1;
                req_valid = 1'b0;
                return;
            end
            waited++;
            if (waited > 200) begin
                n_cmp++;
                n_bad++;
                $display("FAIL accept_timeout @%h: got no accept in %0d cycles, want accept", addr, waited);
                req_valid = 1'b0;
                @(posedge clk); #1;
                return;
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic ld(input logic [31:0] off, input logic [1:0] size, input logic uns,
                      input logic [31:0] exp_rdata, input logic exp_err);
        time t;
        send(1'b0, BASE + off, size, uns, 32'hA5A5_A5A5, exp_rdata, exp_err, 1'b1, t);
    endtask

    task automatic st(input logic [31:0] off, input logic [1:0] size, input logic [31:0] wdata,
                      input logic exp_err);
        time t;
        send(1'b1, BASE + off, size, 1'b0, wdata, 32'd0, exp_err, 1'b1, t);
    endtask

    task automatic drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL drain_timeout: got %0d responses outstanding, want 0", exp_q.size());
        end
    endtask

    // Called in cycle 1 after a reset edge: req_ready low for DEPTH cycles, then high.
    task automatic wait_clear();
        for (int i = 1; i <= DEPTH; i++) begin
            @(negedge clk);
            n_cmp++;
            if (req_ready !== 1'b0 || rsp_valid !== 1'b0) begin
                n_bad++;
                $display("FAIL clear_cycle%0d: got req_ready=%b rsp_valid=%b, want 0 0", i, req_ready, rsp_valid);
            end
            @(posedge clk); #1;
        end
        @(negedge clk);
        n_cmp++;
        if (req_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL clear_done: got req_ready=%b in cycle %0d, want 1", req_ready, DEPTH + 1);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        wait_clear();
        n_cmp++;
        if (rsp_rdata !== 32'd0 || rsp_err !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_rsp: got rdata=%h err=%b, want 00000000 0", rsp_rdata, rsp_err);
        end
    endtask

    task automatic test_clear_zero();
        ld(32'h10, SZW, 1'b0, 32'd0, 1'b0);
        for (int i = 0; i < DEPTH; i++) ld(32'(4 * i), SZW, 1'b0, 32'd0, 1'b0);
        drain();
    endtask

    task automatic test_store_load();
        st(32'h20, SZW, 32'hDEAD_BEEF, 1'b0);
        st(32'h21, SZB, 32'hABCD_EF11, 1'b0);
        st(32'h23, SZB, 32'h1234_5622, 1'b0);
        ld(32'h20, SZW, 1'b0, 32'h22AD_11EF, 1'b0);
        ld(32'h22, SZB, 1'b0, 32'hFFFF_FFAD, 1'b0);
        ld(32'h22, SZH, 1'b1, 32'h0000_22AD, 1'b0);
        ld(32'h20, SZH, 1'b0, 32'h0000_11EF, 1'b0);
        ld(32'h23, SZB, 1'b1, 32'h0000_0022, 1'b0);
        ld(32'h21, SZB, 1'b0, 32'h0000_0011, 1'b0);
        st(32'h2E, SZH, 32'hFFFF_8001, 1'b0);
        ld(32'h2C, SZW, 1'b0, 32'h8001_0000, 1'b0);
        ld(32'h2E, SZH, 1'b0, 32'hFFFF_8001, 1'b0);
        ld(32'h2E, SZH, 1'b1, 32'h0000_8001, 1'b0);
        ld(32'h2F, SZB, 1'b1, 32'h0000_0080, 1'b0);
        drain();
    endtask

    task automatic test_misaligned();
        ld(32'h21, SZH, 1'b1, 32'd0, 1'b1);
        ld(32'h22, SZW, 1'b0, 32'd0, 1'b1);
        st(32'h22, SZW, 32'hFFFF_FFFF, 1'b1);
        st(32'h23, SZH, 32'hFFFF_FFFF, 1'b1);
        st(32'h20, SZX, 32'hFFFF_FFFF, 1'b1);
        ld(32'h20, SZX, 1'b0, 32'd0, 1'b1);
        ld(32'h20, SZW, 1'b0, 32'h22AD_11EF, 1'b0);
        drain();
    endtask

    task automatic test_out_of_range();
        ld(32'(4 * DEPTH), SZW, 1'b0, 32'd0, 1'b1);
        ld(32'hFFFF_FFFC, SZW, 1'b0, 32'd0, 1'b1);
        st(32'(4 * DEPTH), SZW, 32'hFFFF_FFFF, 1'b1);
        ld(32'h0, SZW, 1'b0, 32'd0, 1'b0);
        st(32'(4 * DEPTH - 4), SZW, 32'hCAFE_F00D, 1'b0);
        ld(32'(4 * DEPTH - 4), SZW, 1'b0, 32'hCAFE_F00D, 1'b0);
        ld(32'(4 * DEPTH - 1), SZB, 1'b0, 32'hFFFF_FFCA, 1'b0);
        drain();
    endtask

    task automatic test_backpressure();
        time t0, t1, t2, tx;
        st(32'h24, SZW, 32'h1234_5678, 1'b0);
        st(32'h28, SZW, 32'h9ABC_DEF0, 1'b0);
        drain();
        rsp_ready = 1'b0;
        send(1'b0, BASE + 32'h20, SZW, 1'b0, 32'd0, 32'h22AD_11EF, 1'b0, 1'b1, tx);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            n_cmp++;
            if (req_ready !== 1'b0 || rsp_valid !== 1'b1 || rsp_rdata !== 32'h22AD_11EF || rsp_err !== 1'b0) begin
                n_bad++;
                $display("FAIL hold%0d: got ready=%b valid=%b rdata=%h err=%b, want 0 1 22ad11ef 0",
                         i, req_ready, rsp_valid, rsp_rdata, rsp_err);
            end
            @(posedge clk); #1;
        end
        rsp_ready = 1'b1;
        send(1'b0, BASE + 32'h20, SZW, 1'b0, 32'd0, 32'h22AD_11EF, 1'b0, 1'b1, t0);
        send(1'b0, BASE + 32'h24, SZW, 1'b0, 32'd0, 32'h1234_5678, 1'b0, 1'b1, t1);
        send(1'b0, BASE + 32'h28, SZW, 1'b0, 32'd0, 32'h9ABC_DEF0, 1'b0, 1'b1, t2);
        n_cmp++;
        if ((t1 - t0) != 10 || (t2 - t1) != 10) begin
            n_bad++;
            $display("FAIL back_to_back: got accept gaps %0t %0t, want 10 10", t1 - t0, t2 - t1);
        end
        drain();
    endtask

    task automatic test_reset_pending();
        time tx;
        rsp_ready = 1'b0;
        send(1'b0, BASE + 32'h20, SZW, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0, tx);
        rst = 1'b1;
        @(posedge clk); #1;
        rst       = 1'b0;
        rsp_ready = 1'b1;
        wait_clear();
        n_cmp++;
        if (rsp_rdata !== 32'd0 || rsp_err !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_pending_rsp: got rdata=%h err=%b, want 00000000 0", rsp_rdata, rsp_err);
        end
        ld(32'h20, SZW, 1'b0, 32'd0, 1'b0);
        ld(32'h2C, SZW, 1'b0, 32'd0, 1'b0);
        ld(32'(4 * DEPTH - 4), SZW, 1'b0, 32'd0, 1'b0);
        drain();
    endtask

    initial begin
        rst          = 1'b1;
        req_valid    = 1'b0;
        req_we       = 1'b0;
        req_addr     = '0;
        req_size     = SZW;
        req_unsigned = 1'b0;
        req_wdata    = '0;
        rsp_ready    = 1'b1;

        test_reset();
        test_clear_zero();
        test_store_load();
        test_misaligned();
        test_out_of_range();
        test_backpressure();
        test_reset_pending();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
